// File: rtl/mult_seq_ctrl.sv
// Sequencer for a bit-serial N x N shift-add multiplier: takes operand pairs,
// feeds one multiplier bit per cycle LSB first, then holds the 2N-bit product.
module mult_seq_ctrl #(
   parameter int N  = 32,
   parameter int CW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
   input  logic           abort,
   output logic           dp_rst,
   output logic [N-1:0]   dp_g,
   output logic           dp_e,
   input  logic [2*N-1:0] dp_o,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] prod,
   output logic           busy,
   output logic [15:0]    op_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     a_reg_q, a_reg_d;
   logic [N-1:0]     b_reg_q, b_reg_d;
   logic [2*N-1:0]   prod_q, prod_d;
   logic [15:0]      op_count_q, op_count_d;
   logic             last_cnt;
   logic [N-1:0]     b_shift;

   assign last_cnt = (cnt_q == CW'(N-1));
   // Shift rather than index so the bit select is width-clean for any CW.
   assign b_shift  = b_reg_q >> cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         a_reg_q    <= '0;
         b_reg_q    <= '0;
         prod_q     <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_reg_q    <= a_reg_d;
         b_reg_q    <= b_reg_d;
         prod_q     <= prod_d;
         op_count_q <= op_count_d;
      end
   end

   // abort wins over both the final capture and the output handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_RUN;
         S_RUN:   if (abort) state_d = S_IDLE;
                  else if (last_cnt) state_d = S_DONE;
         S_DONE:  if (abort || out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      a_reg_d    = a_reg_q;
      b_reg_d    = b_reg_q;
      prod_d     = prod_q;
      op_count_d = op_count_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_reg_d = a_in;
               b_reg_d = b_in;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (abort || last_cnt) cnt_d = '0;
            else                   cnt_d = cnt_q + CW'(1);
            if (!abort && last_cnt) prod_d = dp_o;
         end
         S_DONE: begin
            if (!abort && out_ready) op_count_d = op_count_q + 16'd1;
         end
         default: cnt_d = '0;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      dp_rst    = 1'b1;
      dp_g      = '0;
      dp_e      = 1'b0;
      case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_RUN: begin
            busy   = 1'b1;
            dp_rst = 1'b0;
            dp_g   = a_reg_q;
            dp_e   = b_shift[0];
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   assign prod     = prod_q;
   assign op_count = op_count_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural shift-add datapath stub.
module tb_mult_seq_ctrl;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, abort, dp_rst, dp_e, out_valid, out_ready, busy;
   logic [N-1:0]  a_in, b_in, dp_g;
   logic [63:0]   dp_o, prod;
   logic [15:0]   op_count;

   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;

   mult_seq_ctrl #(.N(N), .CW(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .abort(abort), .dp_rst(dp_rst), .dp_g(dp_g),
      .dp_e(dp_e), .dp_o(dp_o), .out_valid(out_valid), .out_ready(out_ready),
      .prod(prod), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Datapath stub: accumulates g<<k when bit k is set; o is combinational.
   logic [63:0] acc;
   logic [5:0]  idx;
   assign dp_o = acc + (dp_e ? ({32'd0, dp_g} << idx) : 64'd0);
   always @(posedge clk) begin
      if (dp_rst) begin
         acc <= '0;
         idx <= '0;
      end else begin
         acc <= dp_o;
         idx <= idx + 6'd1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_dp_rst"}, 64'(dp_rst), 64'd1);
      check({tag, "_dp_e"}, 64'(dp_e), 64'd0);
      check({tag, "_dp_g"}, 64'(dp_g), 64'd0);
   endtask

   // Full operation with out_ready high; ends in the IDLE cycle after DONE.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [63:0] exp);
      @(negedge clk);
      in_valid = 1'b1; a_in = a; b_in = b; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("op_busy", 64'(busy), 64'd1);
      check("op_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < N; i++) begin
         checks++;
         assert (dp_e === b[i] && dp_g === a && !out_valid && !dp_rst) else begin
            failures++;
            $error("FAIL run_bit%0d observed=e%b g%h v%b r%b expected=e%b g%h v0 r0",
                   i, dp_e, dp_g, out_valid, dp_rst, b[i], a);
         end
         @(negedge clk);
      end
      check("op_out_valid", 64'(out_valid), 64'd1);
      check("op_prod", prod, exp);
      exp_cnt++;
      @(negedge clk);
      check("op_valid_drop", 64'(out_valid), 64'd0);
      check("op_idle_ready", 64'(in_ready), 64'd1);
      check("op_count", 64'(op_count), 64'(exp_cnt));
   endtask

   logic [31:0] ta [4];
   logic [31:0] tb [4];
   logic [63:0] tp [4];

   initial begin
      rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check_reset_vals("rst");
      check("rst_prod", prod, 64'd0);
      check("rst_opcnt", 64'(op_count), 64'd0);

      // 1,2: basic products and edge operands
      do_op(32'd3, 32'd5, 64'h0000_0000_0000_000F);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      do_op(32'h1234_5678, 32'd0, 64'd0);

      // 3: backpressure
      @(negedge clk);
      in_valid = 1'b1; a_in = 32'd11; b_in = 32'd13; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (N) @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_prod", prod, 64'd143);
      in_valid = 1'b1; a_in = 32'd99; b_in = 32'd99;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         assert (out_valid === 1'b1 && in_ready === 1'b0 && prod === 64'd143) else begin
            failures++;
            $error("FAIL bp_hold%0d observed=v%b r%b p%h expected=v1 r0 p8f", i, out_valid, in_ready, prod);
         end
      end
      out_ready = 1'b1; a_in = 32'd6; b_in = 32'd7;
      @(negedge clk);
      exp_cnt++;
      check("bp_idle_ready", 64'(in_ready), 64'd1);
      check("bp_idle_valid", 64'(out_valid), 64'd0);
      check("bp_opcnt", 64'(op_count), 64'(exp_cnt));
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_accept", 64'(busy), 64'd1);
      repeat (N) @(negedge clk);
      check("bp_prod2", prod, 64'd42);
      @(negedge clk);
      exp_cnt++;
      check("bp_opcnt2", 64'(op_count), 64'(exp_cnt));

      // 4: abort at cnt=10
      @(negedge clk);
      in_valid = 1'b1; a_in = 32'd1000; b_in = 32'd2000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_reset_vals("abort");
      check("abort_opcnt", 64'(op_count), 64'(exp_cnt));
      check("abort_prod", prod, 64'd42);
      do_op(32'd7, 32'd9, 64'd63);

      // 5: reset at cnt=20
      @(negedge clk);
      in_valid = 1'b1; a_in = 32'd5; b_in = 32'hFFFF_FFFF;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_cnt = 0;
      check_reset_vals("midrst");
      check("midrst_prod", prod, 64'd0);
      check("midrst_opcnt", 64'(op_count), 64'd0);
      do_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

      // 6: back-to-back after a fresh reset
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      ta[0] = 32'd10;        tb[0] = 32'd20;        tp[0] = 64'd200;
      ta[1] = 32'h0000_FFFF; tb[1] = 32'h0001_0001; tp[1] = 64'h0000_0000_FFFF_FFFF;
      ta[2] = 32'hDEAD_BEEF; tb[2] = 32'd1;         tp[2] = 64'h0000_0000_DEAD_BEEF;
      ta[3] = 32'h8000_0001; tb[3] = 32'h8000_0001; tp[3] = 64'h4000_0001_0000_0001;
      out_ready = 1'b1;
      begin
         int k = 0, j = 0, prev = -1;
         for (int c = 0; c < 4 * (N + 2) + 2; c++) begin
            if (in_ready) begin
               if (k < 4) begin
                  if (prev >= 0) check("b2b_spacing", 64'(c - prev), 64'(N + 2));
                  prev = c;
                  in_valid = 1'b1; a_in = ta[k]; b_in = tb[k];
                  k++;
               end else in_valid = 1'b0;
            end
            if (out_valid) begin
               if (j < 4) check("b2b_prod", prod, tp[j]);
               j++;
            end
            @(negedge clk);
         end
         check("b2b_accepts", 64'(k), 64'd4);
         check("b2b_outputs", 64'(j), 64'd4);
         check("b2b_opcnt", 64'(op_count), 64'd4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencer for the bit-serial N×N shift-add multiplier datapath, which consumes one multiplier bit per clock over N clocks.
- Accepts operand pairs over a valid/ready handshake and manages the datapath:
  - clears it,
  - drives the multiplicand and one multiplier bit per cycle, LSB first,
  - counts N cycles,
  - captures the 2N-bit product and presents it on a valid/ready output handshake.
- Sits between the operand source and the multiplier instance; it owns the multiplier's reset.

Parameters:
- N, 32, operand width. Also the number of RUN cycles per operation. Legal range 2..64.
- CW, 6, counter width. Must satisfy 2^CW ≥ N.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept an operand pair.
- a_in  input  N  multiplicand.
- b_in  input  N  multiplier.
- abort  input  1  synchronous cancel of the current operation.
- dp_rst  output  1  active-high reset to the multiplier datapath.
- dp_g  output  N  multiplicand to the datapath (its g_input).
- dp_e  output  1  current multiplier bit to the datapath (its e_input).
- dp_o  input  2N  datapath combinational product/partial output (its o).
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- prod  output  2N  captured product.
- busy  output  1  high in RUN or DONE.
- op_count  output  16  completed-and-accepted operation count; wraps.

Behaviour:
- One clock. Reset is synchronous and active-low: on any clk edge with rst=0 the block enters the reset state below.
- Reset values:
  - state=IDLE, cnt=0, a_reg=0, b_reg=0, prod=0, op_count=0.
  - out_valid=0, in_ready=1, busy=0, dp_rst=1, dp_e=0, dp_g=0.
- States: IDLE, RUN, DONE. All outputs are decoded from registers only; there are no combinational paths from inputs to outputs.
- IDLE:
  - in_ready=1, dp_rst=1 (datapath held cleared).
  - On in_valid=1: latch a_in → a_reg and b_in → b_reg, set cnt=0, go to RUN.
- RUN:
  - in_ready=0, dp_rst=0, dp_g=a_reg, dp_e=b_reg[cnt].
  - Each cycle cnt increments.
  - In the cycle with cnt=N-1, dp_o holds the full product; on that edge capture prod←dp_o and go to DONE.
- DONE:
  - out_valid=1, dp_rst=1, dp_e=0, dp_g=0. prod is held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid→0, op_count increments, go to IDLE.
  - A new operand is accepted only from IDLE. There is no same-cycle turnaround in DONE: one bubble cycle per operation.
- Outside RUN: dp_e=0 and dp_g=0.
- Latency:
  - Operand accepted on edge T.
  - RUN occupies cycles T+1..T+N.
  - out_valid is first high in cycle T+N+1.
  - Throughput is one product per N+2 cycles with out_ready tied high.
- Abort:
  - In RUN or DONE, abort=1 at an edge → IDLE. prod is unchanged, op_count is not incremented, out_valid=0 next cycle, dp_rst=1 next cycle.
  - In IDLE, abort is ignored and in_valid is still accepted.
  - abort has priority over out_ready and over the cnt=N-1 capture.
- Reset mid-operation: identical to the reset state, regardless of state. Any partial product is discarded.
- Counter: cnt does not wrap within an operation and equals N-1 only in the final RUN cycle.
- op_count: wraps from 0xFFFF to 0.
- Arithmetic: product is unsigned N×N → 2N bits, matching the datapath.

Test Plan:
1. Reset, then a_in=3, b_in=5, in_valid pulse at edge T, out_ready=1 → during RUN, dp_e sequence 1,0,1,0,…0. out_valid is high in cycle T+33 only, with prod=0x000000000000000F. op_count=1.
2. a_in=b_in=0xFFFFFFFF → prod=0xFFFFFFFE00000001. a_in=0x12345678, b_in=0 → prod=0, and dp_e=0 throughout RUN.
3. Backpressure: out_ready=0 for 10 cycles after out_valid rises → prod stable, in_ready=0, a second in_valid is not accepted. out_ready=1 → IDLE next cycle. The next operand is accepted one cycle later.
4. abort asserted at cnt=10 of RUN → IDLE next cycle, dp_rst=1, out_valid never rises, op_count unchanged. A following operation 7×9 yields prod=63.
5. rst=0 for one edge at cnt=20 → all outputs at reset values the next cycle. A subsequent 0x80000000×2 yields prod=0x0000000100000000.
6. Back-to-back: 4 operations, in_valid held high, out_ready=1 → in_ready pulses once per 34 cycles. op_count=4, and all four products are correct.
